// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I MEM-stage load/store unit driving a req/gnt/rvalid data bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing alignment.
module lsu_mem_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_mem_write_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [DATA_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_store_data_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  kill_q, kill_d;
    logic                  is_load_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic                  req_q, we_q, done_q, err_q;
    logic                  done_d, err_d;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, ldata_q;
    logic [3:0]            be_q;

    logic                  accept;
    logic                  illegal;
    logic                  fault;
    logic [1:0]            size;
    logic [1:0]            off_eff;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [15:0]           shifted;
    logic [DATA_WIDTH-1:0] ldata_d;

    assign accept = (state_q == IDLE) && ex_valid_i && (ex_mem_read_i || ex_mem_write_i) && !flush_i;

    // funct3[1:0] encodes access size for both loads and stores (0=byte, 1=half, 2=word).
    always_comb begin
        illegal = 1'b0;
        if (ex_mem_read_i && ex_mem_write_i) begin
            illegal = 1'b1;
        end else if (ex_mem_read_i) begin
            illegal = (ex_funct3_i[1:0] == 2'b11);
        end else begin
            illegal = (ex_funct3_i >= 3'b011);
        end
        size = ex_funct3_i[1:0];
        case (size)
            2'b00:   off_eff = ex_addr_i[1:0];
            2'b01:   off_eff = {ex_addr_i[1], 1'b0};
            default: off_eff = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;

    always_comb begin
        case (size)
            2'b01:   misalign = ex_addr_i[0];
            2'b10:   misalign = |ex_addr_i[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign fault = illegal | misalign;
`else
    assign fault = illegal;
`endif

    always_comb begin
        case (size)
            2'b00: begin
                be_d    = 4'b0001 << off_eff;
                wdata_d = {(DATA_WIDTH/8){ex_store_data_i[7:0]}};
            end
            2'b01: begin
                be_d    = off_eff[1] ? 4'b1100 : 4'b0011;
                wdata_d = {(DATA_WIDTH/16){ex_store_data_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = ex_store_data_i;
            end
        endcase
    end

    always_comb begin
        shifted = 16'(dmem_rdata_i >> {off_q, 3'b000});
        case (funct3_q)
            FUNCT3_LB:  ldata_d = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  ldata_d = {{(DATA_WIDTH-16){shifted[15]}}, shifted};
            FUNCT3_LBU: ldata_d = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            FUNCT3_LHU: ldata_d = {{(DATA_WIDTH-16){1'b0}}, shifted};
            default:    ldata_d = dmem_rdata_i;
        endcase
    end

    // A grant wins over a same-cycle flush; a flush in WAIT is remembered until rvalid drains.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (accept) begin
                    state_d = fault ? DONE : REQ;
                    err_d   = fault;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = is_load_q ? WAIT : DONE;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (dmem_rvalid_i) begin
                    state_d = (kill_q || flush_i) ? IDLE : DONE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            kill_q    <= 1'b0;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            ldata_q   <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            req_q   <= (state_d == REQ);
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept && !fault) begin
                is_load_q <= ex_mem_read_i;
                funct3_q  <= ex_funct3_i;
                off_q     <= off_eff;
                we_q      <= ex_mem_write_i;
                addr_q    <= {ex_addr_i[DATA_WIDTH-1:2], 2'b00};
                be_q      <= be_d;
                wdata_q   <= wdata_d;
            end
            if ((state_q == WAIT) && dmem_rvalid_i && !kill_q && !flush_i) begin
                ldata_q <= ldata_d;
            end
        end
    end

    assign stall_o      = accept || (state_q == REQ) || (state_q == WAIT);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign load_data_o  = ldata_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

endmodule
